// File: rtl/mbscore_mem_arbiter.sv
// mbscore_mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store data port of the multicycle core. One access at a time,
// variable-latency ready handshake, and an abort with bus_err when the memory stalls.
module mbscore_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int PRIO_DATA  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  bus_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {S_IDLE, S_ACC_I, S_ACC_D, S_DONE} state_t;

  localparam logic       PRIO_FIXED = (PRIO_DATA != 0);
  // Counter value at which one more stalled cycle means the access is abandoned.
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  localparam logic [1:0] G_IDLE = 2'b00;
  localparam logic [1:0] G_INSTR = 2'b01;
  localparam logic [1:0] G_DATA = 2'b10;
  localparam logic [1:0] G_DONE = 2'b11;

  state_t                  state_q, state_d;
  logic                    last_d_q, last_d_d;   // 1: previous grant went to data port
  logic                    cur_d_q, cur_d_d;     // 1: access in flight belongs to data port
  logic [7:0]              cnt_q, cnt_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    i_ack_q, i_ack_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic                    d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    bus_err_q, bus_err_d;
  logic                    busy_q, busy_d;
  logic [1:0]              grant_q, grant_d;
  logic                    pick_data;
  logic                    acc_to;

  // Next-state: arbitration in IDLE, completion/timeout in ACC, bookkeeping in DONE.
  always_comb begin
    // Data wins if alone, or under fixed priority, or if instr was granted last.
    pick_data   = d_req & (~i_req | PRIO_FIXED | ~last_d_q);
    acc_to      = (cnt_q == TO_LAST);

    state_d     = state_q;
    last_d_d    = last_d_q;
    cur_d_d     = cur_d_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    grant_d     = grant_q;

    case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          mem_en_d = 1'b1;
          cnt_d    = 8'd0;
          cur_d_d  = pick_data;
          if (pick_data) begin
            state_d     = S_ACC_D;
            grant_d     = G_DATA;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = S_ACC_I;
            grant_d     = G_INSTR;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      S_ACC_I, S_ACC_D: begin
        // A ready on the timeout edge still wins: the access completes normally.
        if (mem_ready | acc_to) begin
          state_d   = S_DONE;
          grant_d   = G_DONE;
          mem_en_d  = 1'b0;
          cnt_d     = 8'd0;
          bus_err_d = ~mem_ready;
          if (state_q == S_ACC_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_ready)
              d_rdata_d = '0;
            else if (!mem_we_q)
              d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // Requester drops req during the ack cycle, so IDLE never sees it again.
        state_d  = S_IDLE;
        grant_d  = G_IDLE;
        last_d_d = cur_d_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = G_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and every output are registered; reset clears them all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b0;
      cur_d_q     <= 1'b0;
      cnt_q       <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= G_IDLE;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cur_d_q     <= cur_d_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mbscore_mem_arbiter.sv
// Bench for mbscore_mem_arbiter: a fixed-priority and a round-robin instance share the
// stimulus; the unused one is held in reset and the active one's outputs are checked
// against a transaction-level model (service order, memory contents, rdata registers).
module tb_mbscore_mem_arbiter;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  bit          sel;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic        x_i_ack[2], x_d_ack[2], x_bus_err[2], x_mem_en[2], x_mem_we[2], x_busy[2];
  logic [31:0] x_i_rdata[2], x_d_rdata[2], x_mem_addr[2], x_mem_wdata[2];
  logic [1:0]  x_grant[2];

  logic        i_ack, d_ack, bus_err, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;

  assign i_ack     = x_i_ack[sel];
  assign d_ack     = x_d_ack[sel];
  assign bus_err   = x_bus_err[sel];
  assign mem_en    = x_mem_en[sel];
  assign mem_we    = x_mem_we[sel];
  assign busy      = x_busy[sel];
  assign i_rdata   = x_i_rdata[sel];
  assign d_rdata   = x_d_rdata[sel];
  assign mem_addr  = x_mem_addr[sel];
  assign mem_wdata = x_mem_wdata[sel];
  assign grant     = x_grant[sel];

  mbscore_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO), .PRIO_DATA(1)) u_prio (
    .clk(clk), .rst_n(rst0_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(x_i_ack[0]), .i_rdata(x_i_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(x_d_ack[0]), .d_rdata(x_d_rdata[0]), .bus_err(x_bus_err[0]),
    .mem_en(x_mem_en[0]), .mem_we(x_mem_we[0]), .mem_addr(x_mem_addr[0]),
    .mem_wdata(x_mem_wdata[0]), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(x_busy[0]), .grant(x_grant[0]));

  mbscore_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO), .PRIO_DATA(0)) u_rr (
    .clk(clk), .rst_n(rst1_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(x_i_ack[1]), .i_rdata(x_i_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(x_d_ack[1]), .d_rdata(x_d_rdata[1]), .bus_err(x_bus_err[1]),
    .mem_en(x_mem_en[1]), .mem_we(x_mem_we[1]), .mem_addr(x_mem_addr[1]),
    .mem_wdata(x_mem_wdata[1]), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(x_busy[1]), .grant(x_grant[1]));

  // reference model state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [logic [31:0]];
  bit          last_d;
  logic [31:0] e_ird, e_drd;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h0F0F};
  endfunction

  // memory latency: cycles of mem_en before ready; >= TO means never ready
  function automatic int pick_lat();
    int t;
    t = int'($urandom_range(0, 9));
    if (t < 6) return t % 4;
    if (t == 6) return TO - 1;
    if (t == 7) return 99;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({i_ack, d_ack, bus_err, mem_en, mem_we, busy, grant}), 64'd0);
    chk({tag, "_irdata"}, 64'(i_rdata), 64'd0);
    chk({tag, "_drdata"}, 64'(d_rdata), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({i_ack, d_ack, bus_err, mem_en, busy, grant}), 64'd0);
  endtask

  // One scenario: present the requests together, play the memory, check every cycle
  // until all expected acks arrived. lat < 0 picks a random latency.
  task automatic run_scn(input bit ri, input bit rd, input bit we, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd,
                         input int lat_i, input int lat_d, input bit drop_i, input bit drop_d);
    bit order[2];
    int nexp, served, run_len, cur_len, ack_c, lat;
    bit cur_to, port, first_d;
    nexp = 0; served = 0; run_len = 0; cur_len = 0; ack_c = 0; cur_to = 0; port = 0;
    order[0] = 0; order[1] = 0;
    if (ri && rd) begin
      first_d  = (sel == 0) ? 1'b1 : !last_d;
      order[0] = first_d;
      order[1] = !first_d;
      nexp     = 2;
    end else begin
      order[0] = rd;
      nexp     = 1;
    end
    i_req = ri; i_addr = ia; d_req = rd; d_we = we; d_addr = da; d_wdata = wd;
    mem_ready = 1'b0;
    for (int c = 1; c <= 120 && served < nexp; c++) begin
      @(negedge clk);
      if (mem_en) begin
        port = order[served];
        if (run_len == 0) begin
          chk("start_cycle", 64'(c), 64'(served == 0 ? 1 : ack_c + 2));
          lat = port ? lat_d : lat_i;
          if (lat < 0) lat = pick_lat();
          cur_to  = (lat >= TO);
          cur_len = cur_to ? TO : lat + 1;
          if (port && drop_d) d_req = 1'b0;
          if (!port && drop_i) i_req = 1'b0;
        end
        chk("mem_addr", 64'(mem_addr), 64'(port ? da : ia));
        chk("mem_we", 64'(mem_we), 64'(port & we));
        if (port & we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("acc_flags", 64'({busy, grant, i_ack, d_ack, bus_err}),
            64'({1'b1, port ? 2'b10 : 2'b01, 3'b000}));
        run_len++;
        chk("acc_len", 64'(run_len > cur_len), 64'd0);
        if (!cur_to && run_len == cur_len) begin
          mem_ready = 1'b1;
          mem_rdata = mrd(port ? da : ia);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else if (run_len != 0) begin
        port = order[served];
        chk("ack_len", 64'(run_len), 64'(cur_len));
        chk("ack_flags", 64'({busy, grant, i_ack, d_ack, bus_err}),
            64'({1'b1, 2'b11, !port, port, cur_to}));
        if (cur_to) begin
          if (port) e_drd = '0; else e_ird = '0;
        end else if (!port) e_ird = mrd(ia);
        else if (!we) e_drd = mrd(da);
        else mem[da] = wd;
        last_d = port;
        if (port) d_req = 1'b0; else i_req = 1'b0;
        served++; run_len = 0; ack_c = c;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        chk_idle("wait_flags");
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      chk("i_rdata", 64'(i_rdata), 64'(e_ird));
      chk("d_rdata", 64'(d_rdata), 64'(e_drd));
    end
    chk("served", 64'(served), 64'(nexp));
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("post_idle");
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_random(input int n);
    int m;
    for (int k = 0; k < n; k++) begin
      m = int'($urandom_range(1, 3));
      run_scn(m[0], m[1], 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)) << 2,
              32'h1000 + (32'($urandom_range(0, 7)) << 2), $urandom,
              -1, -1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    int w;
    sel = 0; rst0_n = 1'b0; rst1_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    last_d = 0; e_ird = '0; e_drd = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst0_n = 1'b1;
    @(negedge clk);

    // fixed-priority instance: directed cases
    mem[32'h40] = 32'h2001000A;
    run_scn(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0);                // single fetch
    chk("fetch_value", 64'(i_rdata), 64'h2001000A);
    run_scn(1, 1, 0, 32'h44, 32'h100, 32'h0, 0, 0, 0, 0);              // data before instr
    run_scn(0, 1, 1, 32'h0, 32'h8, 32'hDEADBEEF, 0, 3, 0, 0);          // stalled store
    run_scn(0, 1, 0, 32'h0, 32'h8, 32'h0, 0, 1, 0, 0);                 // read it back
    chk("store_readback", 64'(d_rdata), 64'hDEADBEEF);
    run_scn(0, 1, 0, 32'h0, 32'h10, 32'h0, 0, 99, 0, 0);               // data timeout
    run_scn(0, 1, 0, 32'h0, 32'h14, 32'h0, 0, 0, 0, 0);                // normal after timeout
    run_scn(1, 0, 0, 32'h80, 32'h0, 32'h0, 99, 0, 0, 0);               // instr timeout
    run_scn(0, 1, 0, 32'h0, 32'h18, 32'h0, 0, TO - 1, 0, 0);           // ready on timeout edge
    run_scn(1, 1, 0, 32'h84, 32'h1C, 32'h0, 2, 2, 1, 1);               // req dropped early
    run_random(40);

    // reset in the middle of a data access
    i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 0;
    w = 0;
    while (!mem_en && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("rst_acc_started", 64'(mem_en), 64'd1);
    @(negedge clk);
    #2 rst0_n = 1'b0;
    #1 chk_all_zero("async_rst");
    d_req = 0;
    @(negedge clk);
    chk_all_zero("rst_hold");
    #2 rst0_n = 1'b1;
    last_d = 0; e_ird = '0; e_drd = '0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    run_scn(1, 0, 0, 32'h48, 32'h0, 32'h0, -1, 0, 0, 0);

    // round-robin instance
    rst0_n = 1'b0; sel = 1;
    last_d = 0; e_ird = '0; e_drd = '0;
    @(negedge clk);
    chk_all_zero("rr_reset");
    rst1_n = 1'b1;
    @(negedge clk);
    repeat (3) run_scn(1, 1, 0, 32'h60, 32'h1004, 32'h0, 1, 0, 0, 0);  // D,I,D,I,D,I
    run_scn(0, 1, 0, 32'h0, 32'h1008, 32'h0, 0, 0, 0, 0);
    run_scn(1, 1, 1, 32'h64, 32'h100C, 32'h12345678, 0, 0, 0, 0);      // instr first now
    run_random(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
